// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU front end and controller:
// default field widths, phase encoding and opcode values.
package cpu_pkg;

    localparam int unsigned OPC_W_DEFAULT  = 4;
    localparam int unsigned ADDR_W_DEFAULT = 5;
    localparam int unsigned CNT_W_DEFAULT  = 16;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_SKZ = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_STO = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;

    // Phase after a non-halted edge; 3-bit arithmetic gives the 7 -> 0 wrap.
    function automatic logic [2:0] next_phase(input logic [2:0] cur);
        return cur + 3'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Controller <-> fetch unit signal bundle. The master drives strobes and
// memory data; the slave (fetch unit) returns phase, IR fields, PC and address.
interface fetch_unit_if #(
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [OPC_W+ADDR_W-1:0] data_in;
    logic                    sel;
    logic                    ld_ir;
    logic                    inc_pc;
    logic                    ld_pc;
    logic                    halt;
    logic [2:0]              phase;
    logic [OPC_W-1:0]        opcode;
    logic [ADDR_W-1:0]       ir_addr;
    logic [ADDR_W-1:0]       pc;
    logic [ADDR_W-1:0]       addr;
    logic [CNT_W-1:0]        icount;

    modport master (
        output data_in, sel, ld_ir, inc_pc, ld_pc, halt,
        input  phase, opcode, ir_addr, pc, addr, icount
    );

    modport slave (
        input  data_in, sel, ld_ir, inc_pc, ld_pc, halt,
        output phase, opcode, ir_addr, pc, addr, icount
    );
endinterface

// File: rtl/fetch_unit_phase_counter.sv
// 3-bit phase sequencer for the controller: advances every non-halted edge
// and flags the edge on which phase 7 wraps back to 0.
module fetch_unit_phase_counter
    import cpu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       halt_i,
    output logic [2:0] phase_o,
    output logic       wrap_o
);
    logic [2:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (!halt_i) begin
            phase_d = next_phase(phase_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = !halt_i && (phase_q == PH_STORE);
endmodule

// File: rtl/fetch_unit.sv
// Front-end stage: phase sequencer, instruction register, program counter,
// memory address mux and a saturating retired-instruction counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W  = OPC_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    localparam int unsigned IR_W = OPC_W + ADDR_W;

    logic [IR_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  icount_q, icount_d;
    logic [2:0]        phase;
    logic              wrap;

    fetch_unit_phase_counter u_phase_counter (
        .clk_i   (clk),
        .rst_ni  (rst),
        .halt_i  (bus.halt),
        .phase_o (phase),
        .wrap_o  (wrap)
    );

    // A jump reads the operand held before this edge, so a same-edge IR load
    // only affects the following instruction.
    always_comb begin
        ir_d     = ir_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        if (!bus.halt) begin
            if (bus.ld_ir) begin
                ir_d = bus.data_in;
            end
            if (bus.ld_pc) begin
                pc_d = ir_q[ADDR_W-1:0];
            end else if (bus.inc_pc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (wrap && (icount_q != {CNT_W{1'b1}})) begin
                icount_d = icount_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q     <= '0;
            pc_q     <= '0;
            icount_q <= '0;
        end else begin
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
        end
    end

    assign bus.phase   = phase;
    assign bus.opcode  = ir_q[IR_W-1:ADDR_W];
    assign bus.ir_addr = ir_q[ADDR_W-1:0];
    assign bus.pc      = pc_q;
    assign bus.addr    = bus.sel ? pc_q : ir_q[ADDR_W-1:0];
    assign bus.icount  = icount_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case
// sequences and random stimulus against an abstract reference model.
module tb_fetch_unit;
    logic       clk;
    logic       rst;
    logic [8:0] data_in;
    logic       sel, ld_ir, inc_pc, ld_pc, halt;

    fetch_unit_if #(.OPC_W(4), .ADDR_W(5), .CNT_W(16)) bus ();
    fetch_unit_if #(.OPC_W(4), .ADDR_W(5), .CNT_W(2))  bus_s ();

    assign bus.data_in   = data_in;
    assign bus.sel       = sel;
    assign bus.ld_ir     = ld_ir;
    assign bus.inc_pc    = inc_pc;
    assign bus.ld_pc     = ld_pc;
    assign bus.halt      = halt;
    assign bus_s.data_in = data_in;
    assign bus_s.sel     = sel;
    assign bus_s.ld_ir   = ld_ir;
    assign bus_s.inc_pc  = inc_pc;
    assign bus_s.ld_pc   = ld_pc;
    assign bus_s.halt    = halt;

    fetch_unit #(.OPC_W(4), .ADDR_W(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.OPC_W(4), .ADDR_W(5), .CNT_W(2)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain integers following the behavioural rules.
    int m_phase, m_ir, m_pc, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_all();
        check("phase",    32'(bus.phase),    m_phase);
        check("opcode",   32'(bus.opcode),   m_ir / 32);
        check("ir_addr",  32'(bus.ir_addr),  m_ir % 32);
        check("pc",       32'(bus.pc),       m_pc);
        check("addr",     32'(bus.addr),     sel ? m_pc : m_ir % 32);
        check("icount",   32'(bus.icount),   min_int(m_cnt, 65535));
        check("icount_s", 32'(bus_s.icount), min_int(m_cnt, 3));
    endtask

    task automatic model_step();
        if (!halt) begin
            if (ld_pc)       m_pc = m_ir % 32;
            else if (inc_pc) m_pc = (m_pc + 1) % 32;
            if (ld_ir)       m_ir = int'(data_in);
            if (m_phase == 7) m_cnt++;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input logic [8:0] d, input logic s, input logic li,
                          input logic ip, input logic lp, input logic h);
        data_in = d; sel = s; ld_ir = li; inc_pc = ip; ld_pc = lp; halt = h;
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_phase = 0; m_ir = 0; m_pc = 0; m_cnt = 0;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [8:0] din;
        logic       sel, ld_ir, inc_pc, ld_pc, halt;
        int         phase, opc, ira, pc, addr, icnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        set_in(9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        do_reset();

        // Free run with no strobes.
        for (int i = 0; i < 10; i++) tick();
        check("freerun_phase",  32'(bus.phase), 2);
        check("freerun_icount", 32'(bus.icount), 1);
        check("freerun_pc",     32'(bus.pc), 0);

        // Directed table from a fresh reset; expectations hold after each edge.
        vecs[0] = '{9'b0101_00110,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5,  6,  0,  6, 0};
        vecs[1] = '{9'd0,              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 5,  6,  0,  0, 0};
        vecs[2] = '{9'd0,              1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 5,  6,  1,  1, 0};
        vecs[3] = '{9'd0,              1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 5,  6,  6,  6, 0};
        vecs[4] = '{{4'h3, 5'd20},     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5, 3, 20,  6, 20, 0};
        vecs[5] = '{9'h1FF,            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5, 3, 20,  6,  6, 0};
        vecs[6] = '{9'h1FF,            1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5, 3, 20,  6, 20, 0};
        vecs[7] = '{9'd0,              1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6, 3, 20, 20, 20, 0};
        vecs[8] = '{{4'hA, 5'd12},     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 10, 12, 20, 12, 0};
        vecs[9] = '{9'd0,              1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 10, 12, 12, 12, 1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].din, vecs[i].sel, vecs[i].ld_ir, vecs[i].inc_pc,
                   vecs[i].ld_pc, vecs[i].halt);
            tick();
            check($sformatf("vec%0d_phase", i),  32'(bus.phase),   vecs[i].phase);
            check($sformatf("vec%0d_opcode", i), 32'(bus.opcode),  vecs[i].opc);
            check($sformatf("vec%0d_iraddr", i), 32'(bus.ir_addr), vecs[i].ira);
            check($sformatf("vec%0d_pc", i),     32'(bus.pc),      vecs[i].pc);
            check($sformatf("vec%0d_addr", i),   32'(bus.addr),    vecs[i].addr);
            check($sformatf("vec%0d_icount", i), 32'(bus.icount),  vecs[i].icnt);
        end

        // PC wrap 31 -> 0.
        set_in({4'h1, 5'd31}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_in(9'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);           tick();
        check("pc_at_31", 32'(bus.pc), 31);
        set_in(9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);           tick();
        check("pc_wrap", 32'(bus.pc), 0);

        // Halt at phase 5 for four edges with every strobe asserted.
        set_in(9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8 && m_phase != 5; i++) tick();
        check("halt_start_phase", 32'(bus.phase), 5);
        set_in(9'h1FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("halt_hold_phase", 32'(bus.phase), 5);
        set_in(9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("halt_resume_phase", 32'(bus.phase), 6);

        // Async reset mid-cycle at phase 4 with pc 17.
        set_in({4'h2, 5'd17}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_in(9'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);           tick();
        set_in(9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8 && m_phase != 4; i++) tick();
        check("prereset_phase", 32'(bus.phase), 4);
        check("prereset_pc",    32'(bus.pc), 17);
        #3;
        rst = 1'b0;
        #1;
        check("async_phase", 32'(bus.phase), 0);
        check("async_pc",    32'(bus.pc), 0);
        check("async_ir",    32'(bus.ir_addr), 0);
        do_reset();

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 7) == 0));
            tick();
        end

        // Saturation of the 2-bit counter.
        set_in(9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        check("icount_sat", 32'(bus_s.icount), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage of the small accumulator CPU; sits directly upstream of the controller.
- Owns four pieces of state:
  - the 3-bit phase counter that sequences the controller;
  - the instruction register (IR), which supplies the controller's opcode;
  - the program counter (PC);
  - the memory address mux.
- Consumes the controller's registered strobes (sel, ld_ir, inc_pc, ld_pc, halt), which are launched on negedge clk and stable at posedge clk.
- Also keeps a saturating retired-instruction counter for debug.

Parameters:
- OPC_W, 4, opcode field width (upper IR bits).
- ADDR_W, 5, operand/address field width (lower IR bits); PC width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  OPC_W+ADDR_W  memory read data; captured into IR.
- sel  in  1  address select: 1 = PC, 0 = IR operand.
- ld_ir  in  1  load IR from data_in.
- inc_pc  in  1  increment PC.
- ld_pc  in  1  load PC from IR operand (jump).
- halt  in  1  freeze all state.
- phase  out  3  current phase 0..7; goes to the controller.
- opcode  out  OPC_W  IR[OPC_W+ADDR_W-1:ADDR_W]; goes to the controller.
- ir_addr  out  ADDR_W  IR[ADDR_W-1:0].
- pc  out  ADDR_W  current PC.
- addr  out  ADDR_W  memory address.
- icount  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous): phase=0, IR=0 (so opcode=0 and ir_addr=0), pc=0, icount=0.
  - Outputs follow reset immediately, without waiting for a clock edge.
  - Reset release is sampled at posedge clk; the first update happens on the first posedge with rst=1.
- Phase counter:
  - Each posedge with halt=0: phase <= phase+1, wrapping 7 -> 0.
  - With halt=1: phase holds.
- IR: posedge with ld_ir=1 and halt=0 loads IR <= data_in; otherwise IR holds.
- PC, priority ld_pc > inc_pc, applied only when halt=0:
  - ld_pc=1: pc <= ir_addr. This uses the IR value from before the edge, even if ld_ir=1 on the same edge.
  - else inc_pc=1: pc <= pc+1 mod 2^ADDR_W (31 -> 0 wraps silently).
  - else pc holds.
  - ld_pc and inc_pc both 1: the load wins and no increment occurs.
- addr = sel ? pc : ir_addr. Purely combinational, zero latency.
- icount:
  - Increments on posedge where phase==7 and halt=0, i.e. on each phase wrap.
  - Saturates at 2^CNT_W-1 and never wraps.
- halt=1 freezes phase, IR, PC and icount on every edge while it is high.
  - addr stays combinational.
  - Deassertion resumes from the frozen values on the next posedge.
- Reset mid-instruction (any phase): all state returns to reset values asynchronously; no partial update survives.
- No internal handshake. Latency from any strobe to register output is exactly one posedge.

Decomposition:
- Shared package (cpu_pkg) holds:
  - OPC_W and ADDR_W defaults;
  - phase encoding constants: PH_INST_ADDR=0, PH_INST_FETCH=1, PH_INST_LOAD=2, PH_IDLE=3, PH_OP_ADDR=4, PH_OP_FETCH=5, PH_ALU_OP=6, PH_STORE=7;
  - opcode constants shared with the controller.
- One natural sub-module: phase_counter (3-bit wrap counter with halt enable and phase==7 wrap pulse), instantiated once.
- PC, IR, mux and icount stay flat in fetch_unit.

Test Plan:
- Reset and free-run: rst=0 for 2 cycles, then 1; halt=0, no strobes for 10 cycles.
  -> phase reads 0,1,...,7,0,1; icount=1 after the first wrap; pc=0.
- Fetch: data_in=9'b0101_00110 with ld_ir=1 for one edge, sel=0.
  -> opcode=4'b0101, ir_addr=6, addr=6; then sel=1 -> addr=pc.
- PC wrap and priority:
  - pc=31 with inc_pc=1 -> pc=0.
  - IR operand=12 with ld_pc=1 and inc_pc=1 on the same edge -> pc=12.
- Same-edge IR/PC: IR operand=3; ld_ir=1 with data_in operand=20 and ld_pc=1 on the same edge.
  -> pc=3, ir_addr=20.
- Halt freeze: assert halt at phase=5 for 4 cycles with ld_ir, inc_pc, ld_pc all 1.
  -> phase, IR, pc, icount unchanged; after release, phase goes 6 on the next edge.
- Async reset and saturation:
  - Drop rst mid-cycle at phase=4, pc=17 -> phase=0, pc=0 before the next edge.
  - With CNT_W=2, run 40 cycles -> icount saturates at 3.
